// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit and instruction memory.
//   IMemAddr  : read address (fetch unit -> memory)
//   IMemReq   : read request, level, held until ack or abort (fetch unit -> memory)
//   IMemRdata : read data, valid with IMemAck (memory -> fetch unit)
//   IMemAck   : one-cycle read acknowledge (memory -> fetch unit)
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] IMemAddr;
  logic              IMemReq;
  logic [31:0]       IMemRdata;
  logic              IMemAck;

  modport master (
    output IMemAddr,
    output IMemReq,
    input  IMemRdata,
    input  IMemAck
  );

  modport slave (
    input  IMemAddr,
    input  IMemReq,
    output IMemRdata,
    output IMemAck
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: accepts a fetch request, reads instruction memory
// over a req/ack handshake with a bounded wait, latches the returned word into
// the instruction register together with its decoded immediate, and flags
// misaligned-PC and memory-timeout exceptions.
//   clk, Reset  : clock and synchronous active-high reset
//   LoadIR, PC  : fetch request and address, sampled in IDLE only
//   imem        : instruction-memory read channel (master side)
//   instruction : instruction register; rs1/rs2/rd are its register fields
//   Imm         : registered sign-extended immediate of instruction
//   IRValid     : instruction/Imm hold a completed fetch
//   Busy        : memory read outstanding
//   FetchExc    : one-cycle exception pulse; ExcCause 01 misaligned, 10 timeout
//
// state | meaning
// IDLE  | waiting for LoadIR; outputs hold
// WAIT  | read request outstanding, timeout counter running
module instr_fetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              LoadIR,
  input  logic [ADDR_W-1:0] PC,
  instr_fetch_unit_if.master imem,
  output logic [31:0]       instruction,
  output logic [31:0]       Imm,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic              IRValid,
  output logic              Busy,
  output logic              FetchExc,
  output logic [1:0]        ExcCause
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [7:0]  TMO_LOAD = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t     state;
  logic [7:0] tmo_cnt;

  function automatic logic [31:0] immgen(input logic [31:0] ir);
    logic [31:0] r;
    r = '0;
    case (ir[6:0])
      7'b0000011, 7'b0010011: r = {{20{ir[31]}}, ir[31:20]};
      // jalr shares its opcode with non-standard branch encodings
      7'b1100111: begin
        if (ir[14:12] == 3'b000) r = {{20{ir[31]}}, ir[31:20]};
        else r = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      7'b0100011: r = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      7'b1100011: r = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      7'b0110111: r = {ir[31:12], 12'b0};
      7'b1101111: r = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:    r = '0;
    endcase
    return r;
  endfunction

  assign rs1 = instruction[19:15];
  assign rs2 = instruction[24:20];
  assign rd  = instruction[11:7];

  always_ff @(posedge clk) begin
    if (Reset) begin
      state         <= IDLE;
      imem.IMemReq  <= 1'b0;
      imem.IMemAddr <= '0;
      instruction   <= NOP;
      Imm           <= '0;
      IRValid       <= 1'b0;
      Busy          <= 1'b0;
      FetchExc      <= 1'b0;
      ExcCause      <= 2'b00;
      tmo_cnt       <= '0;
    end else begin
      FetchExc <= 1'b0;
      case (state)
        IDLE: begin
          if (LoadIR) begin
            if (PC[1:0] != 2'b00) begin
              FetchExc <= 1'b1;
              ExcCause <= 2'b01;
              IRValid  <= 1'b0;
            end else begin
              imem.IMemAddr <= PC;
              imem.IMemReq  <= 1'b1;
              IRValid       <= 1'b0;
              ExcCause      <= 2'b00;
              Busy          <= 1'b1;
              // down-counter: reaches zero on the TIMEOUT-th request cycle
              tmo_cnt       <= TMO_LOAD;
              state         <= WAIT;
            end
          end
        end
        WAIT: begin
          // ack is checked first so an ack on the terminal cycle wins
          if (imem.IMemAck) begin
            instruction  <= imem.IMemRdata;
            Imm          <= immgen(imem.IMemRdata);
            imem.IMemReq <= 1'b0;
            IRValid      <= 1'b1;
            Busy         <= 1'b0;
            state        <= IDLE;
          end else if (tmo_cnt == 8'd0) begin
            imem.IMemReq <= 1'b0;
            FetchExc     <= 1'b1;
            ExcCause     <= 2'b10;
            Busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        Reset;
  logic        LoadIR;
  logic [31:0] PC;
  logic [31:0] instruction, Imm;
  logic [4:0]  rs1, rs2, rd;
  logic        IRValid, Busy, FetchExc;
  logic [1:0]  ExcCause;

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit_if #(.ADDR_W(32)) imem ();

  instr_fetch_unit #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .LoadIR      (LoadIR),
    .PC          (PC),
    .imem        (imem),
    .instruction (instruction),
    .Imm         (Imm),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .IRValid     (IRValid),
    .Busy        (Busy),
    .FetchExc    (FetchExc),
    .ExcCause    (ExcCause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          lat;
    logic [31:0] data;
    logic [31:0] imm;
    bit          poke;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic do_fetch(input logic [31:0] pc, input int lat, input logic [31:0] data,
                          input logic [31:0] exp_imm, input bit poke);
    int reqcnt;
    logic [31:0] d;
    d = data;
    @(negedge clk);
    LoadIR = 1'b1;
    PC     = pc;
    @(negedge clk);
    LoadIR = 1'b0;
    PC     = 32'h0000_1000;
    chk("addr_issued", imem.IMemAddr, pc);
    chk("busy_wait", {31'b0, Busy}, 32'd1);
    reqcnt = 0;
    for (int i = 0; i < lat; i++) begin
      if (imem.IMemReq) reqcnt++;
      LoadIR = (poke && i == 1);
      @(negedge clk);
    end
    LoadIR = 1'b0;
    if (imem.IMemReq) reqcnt++;
    chk("irvalid_before_ack", {31'b0, IRValid}, 32'd0);
    chk("addr_stable", imem.IMemAddr, pc);
    imem.IMemAck   = 1'b1;
    imem.IMemRdata = data;
    @(negedge clk);
    imem.IMemAck   = 1'b0;
    imem.IMemRdata = 32'h0;
    chk("req_cycles", reqcnt, lat + 1);
    chk("req_dropped", {31'b0, imem.IMemReq}, 32'd0);
    chk("irvalid", {31'b0, IRValid}, 32'd1);
    chk("instruction", instruction, data);
    chk("imm", Imm, exp_imm);
    chk("rd", {27'b0, rd}, {27'b0, d[11:7]});
    chk("rs1", {27'b0, rs1}, {27'b0, d[19:15]});
    chk("rs2", {27'b0, rs2}, {27'b0, d[24:20]});
    chk("busy_done", {31'b0, Busy}, 32'd0);
    chk("no_exc", {29'b0, FetchExc, ExcCause}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int cnt;
    vecs[0]  = '{32'h40, 0, 32'hFFC10093, 32'hFFFFFFFC, 1'b0};
    vecs[1]  = '{32'h44, 5, 32'hFE208EE3, 32'hFFFFFFFC, 1'b1};
    vecs[2]  = '{32'h48, 1, 32'hFE512E23, 32'hFFFFFFFC, 1'b0};
    vecs[3]  = '{32'h4C, 2, 32'h008000EF, 32'h00000008, 1'b0};
    vecs[4]  = '{32'h50, 3, 32'hFFDFF06F, 32'hFFFFFFFC, 1'b0};
    vecs[5]  = '{32'h54, 0, 32'hFF0280E7, 32'hFFFFFFF0, 1'b0};
    vecs[6]  = '{32'h58, 4, 32'hFF0290E7, 32'hFFFFFFE0, 1'b0};
    vecs[7]  = '{32'h5C, 1, 32'h00C22183, 32'h0000000C, 1'b0};
    vecs[8]  = '{32'h60, 2, 32'hFFF09073, 32'h00000000, 1'b0};
    vecs[9]  = '{32'h64, 6, 32'hFE2081B3, 32'h00000000, 1'b0};
    vecs[10] = '{32'h68, 3, 32'h00512423, 32'h00000008, 1'b0};

    Reset = 1'b1;
    LoadIR = 1'b0;
    PC = 32'h0;
    imem.IMemAck = 1'b0;
    imem.IMemRdata = 32'h0;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    chk("rst_instruction", instruction, 32'h00000013);
    chk("rst_irvalid", {31'b0, IRValid}, 32'd0);
    chk("rst_req", {31'b0, imem.IMemReq}, 32'd0);
    chk("rst_addr", imem.IMemAddr, 32'd0);
    chk("rst_exc", {29'b0, FetchExc, ExcCause}, 32'd0);
    chk("rst_imm", Imm, 32'd0);
    chk("rst_busy", {31'b0, Busy}, 32'd0);

    foreach (vecs[i]) do_fetch(vecs[i].pc, vecs[i].lat, vecs[i].data, vecs[i].imm, vecs[i].poke);

    // ack while idle must be ignored
    @(negedge clk);
    imem.IMemAck = 1'b1;
    imem.IMemRdata = 32'hAAAA5555;
    @(negedge clk);
    imem.IMemAck = 1'b0;
    chk("idle_ack_instr", instruction, 32'h00512423);
    chk("idle_ack_valid", {31'b0, IRValid}, 32'd1);
    chk("idle_ack_req", {31'b0, imem.IMemReq}, 32'd0);

    // misaligned PC
    LoadIR = 1'b1;
    PC = 32'h42;
    @(negedge clk);
    LoadIR = 1'b0;
    chk("mis_exc", {31'b0, FetchExc}, 32'd1);
    chk("mis_cause", {30'b0, ExcCause}, 32'd1);
    chk("mis_irvalid", {31'b0, IRValid}, 32'd0);
    chk("mis_req", {31'b0, imem.IMemReq}, 32'd0);
    chk("mis_instr", instruction, 32'h00512423);
    @(negedge clk);
    chk("mis_pulse_end", {31'b0, FetchExc}, 32'd0);
    chk("mis_cause_held", {30'b0, ExcCause}, 32'd1);
    chk("mis_req_later", {31'b0, imem.IMemReq}, 32'd0);

    // timeout with no ack
    LoadIR = 1'b1;
    PC = 32'h80;
    @(negedge clk);
    LoadIR = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (imem.IMemReq) cnt++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", cnt, 8);
    chk("tmo_req_low", {31'b0, imem.IMemReq}, 32'd0);
    chk("tmo_exc", {31'b0, FetchExc}, 32'd1);
    chk("tmo_cause", {30'b0, ExcCause}, 32'd2);
    chk("tmo_irvalid", {31'b0, IRValid}, 32'd0);
    chk("tmo_busy", {31'b0, Busy}, 32'd0);
    @(negedge clk);
    chk("tmo_pulse_end", {31'b0, FetchExc}, 32'd0);
    chk("tmo_cause_held", {30'b0, ExcCause}, 32'd2);

    // ack on the terminal cycle wins over the timeout
    do_fetch(32'h84, 7, 32'hFFC10093, 32'hFFFFFFFC, 1'b0);
    @(negedge clk);
    chk("late_ack_no_exc", {31'b0, FetchExc}, 32'd0);

    // reset two cycles into WAIT, with an ack on the reset cycle
    LoadIR = 1'b1;
    PC = 32'h100;
    @(negedge clk);
    LoadIR = 1'b0;
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    imem.IMemAck = 1'b1;
    imem.IMemRdata = 32'hFFC10093;
    @(negedge clk);
    Reset = 1'b0;
    imem.IMemAck = 1'b0;
    imem.IMemRdata = 32'h0;
    chk("rstw_req", {31'b0, imem.IMemReq}, 32'd0);
    chk("rstw_instr", instruction, 32'h00000013);
    chk("rstw_irvalid", {31'b0, IRValid}, 32'd0);
    chk("rstw_imm", Imm, 32'd0);
    chk("rstw_busy", {31'b0, Busy}, 32'd0);
    @(negedge clk);
    chk("rstw_req_after", {31'b0, imem.IMemReq}, 32'd0);
    do_fetch(32'h104, 2, 32'h123450B7, 32'h12345000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
